mini_alu_pipe: RTL
==================

Name: mini_alu_pipe

Overview:
Parametrised successor to the team's two-stage mini ALU core. Fetches from an external asynchronous instruction ROM, decodes into a register stage, and executes against an internal register file. Adds SUB, signed multiply with a HI register, branch flush, an output port with a valid/ready handshake, and a HALT state. Sits between the instruction ROM and the board-level LED/peripheral logic.

Parameters:
DATA_W, 16, datapath and register width
ADDR_W, 8, register-address field width; immediate is 2*ADDR_W bits
REG_DEPTH, 16, number of implemented registers (at most 2^ADDR_W)
IP_W, 16, instruction pointer width

Ports:
Clock  in  1  system clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
oIP  out  IP_W  fetch address to the instruction ROM
iInstruction  in  4+3*ADDR_W  ROM data, combinational from oIP; fields are {op[3:0], dest, src1, src0}
oOutData  out  DATA_W  output data register
oOutValid  out  1  oOutData is valid
iOutReady  in  1  consumer accepts oOutData
oHalted  out  1  core is in the HALT state

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - IP=0; decode register = NOP; all registers = 0; HI=0.
  - oOutData=0; oOutValid=0; oHalted=0; state=RUN.
- Pipeline:
  - Fetch: oIP=IP. On each non-stalled edge, the decode register latches iInstruction and IP increments by 1, wrapping from 2^IP_W-1 to 0.
  - Execute: operates on the decode register. Register reads are combinational; writes occur at the end of the execute cycle.
  - No forwarding is needed, because a write lands before the next execute cycle.
- Opcodes (shared package): NOP=0, STO=1, ADD=2, SUB=3, SMUL=4, MFHI=5, BLE=6, JMP=7, OUT=8, HALT=9. Codes 10-15 execute as NOP.
- STO: R[dest] = {src1,src0}, zero-extended or truncated to DATA_W.
- ADD / SUB: R[dest] = R[src0] +/- R[src1], modulo 2^DATA_W; no flags.
- SMUL: signed R[src0]*R[src1] into a 2*DATA_W product. Low half goes to R[dest]; high half goes to HI in the same cycle.
- MFHI: R[dest] = HI.
- BLE: taken if R[src1] <= R[src0], compared unsigned.
- JMP: always taken.
- Taken branch:
  - IP <= dest, zero-extended to IP_W.
  - The decode register loads NOP, flushing exactly one slot.
  - Penalty: one cycle.
- OUT: oOutData <= R[src1]; oOutValid <= 1; state goes to WAIT_OUT.
- WAIT_OUT:
  - IP, the decode register, the register file and HI are all frozen.
  - A transfer occurs on an edge where oOutValid=1 and iOutReady=1. At that edge: oOutValid <= 0; state goes to RUN; the pipeline resumes.
  - If iOutReady is already 1 in the cycle after OUT, the stall lasts exactly one cycle.
  - oOutData holds its value after the transfer.
- HALT:
  - state goes to HALT; oHalted=1; IP and the decode register are frozen; no writes.
  - Only Reset exits HALT.
- Register addresses >= REG_DEPTH: writes are dropped; reads return 0.
- Boundary cases:
  - dest equal to a source: the read uses the old value and the write takes the new one.
  - Reset mid-WAIT_OUT: oOutValid drops immediately (asynchronously).
  - A branch targeting the current IP is legal and produces a tight loop.
- State machine: RUN, WAIT_OUT, HALT. Encoding is free; the states go in the shared package.

Decomposition:
- Shared package: opcode constants, state encoding, and field-slice helpers (op, dest, src1, src0 positions as functions of ADDR_W).
- One sub-module: mini_alu_regfile. It has REG_DEPTH x DATA_W, two combinational read ports and one synchronous write port, with asynchronous active-low clear and the out-of-range rules above.
- The FSM, IP, decode register, HI and output register live in the top module.

Test Plan:
- Reset, then STO R1=0x0005, STO R2=0x0003, ADD R3=R1+R2, OUT R3, with iOutReady=1 → oOutValid pulses for one cycle with oOutData=0x0008; IP advances by 1 per non-stalled cycle.
- SUB with R1=0x0003, R2=0x0005 → R[dest]=0xFFFE. SMUL with 0xFFFF*0x0002 → low half 0xFFFE, HI=0xFFFF; MFHI then copies 0xFFFF.
- BLE with R1=4, R2=4 → taken: the following instruction is flushed (its STO writes nothing) and oIP equals dest on the next cycle. With R2=5 → not taken and no flush.
- OUT with iOutReady=0 held for 5 cycles → oIP, registers and oOutData stay stable and oOutValid stays 1. Raise iOutReady → transfer on that edge, oOutValid=0 next cycle, execution resumes at the next address.
- HALT at address 6 → oHalted=1 and oIP frozen. Assert Reset mid-run and mid-WAIT_OUT → all outputs return to reset values immediately without waiting for a clock edge, and fetch restarts at 0.
- STO to address REG_DEPTH, then OUT of that address → oOutData=0. JMP from the last address wraps IP correctly.

Source files
------------

// File: rtl/mini_alu_pipe_pkg.sv
// Shared definitions for the mini ALU pipeline: opcodes, FSM states and
// instruction field positions expressed as functions of the address width.
package mini_alu_pipe_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 4'd0,
      OP_STO  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_SMUL = 4'd4,
      OP_MFHI = 4'd5,
      OP_BLE  = 4'd6,
      OP_JMP  = 4'd7,
      OP_OUT  = 4'd8,
      OP_HALT = 4'd9
   } opcode_e;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_OUT = 2'd1,
      ST_HALT     = 2'd2
   } state_e;

   // Instruction layout is {op, dest, src1, src0}.
   function automatic int instr_w(input int addr_w);
      return OP_W + 3 * addr_w;
   endfunction

   function automatic int op_lsb(input int addr_w);
      return 3 * addr_w;
   endfunction

   function automatic int dest_lsb(input int addr_w);
      return 2 * addr_w;
   endfunction

   function automatic int src1_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int src0_lsb(input int addr_w);
      return 0 * addr_w;
   endfunction

endpackage

// File: rtl/mini_alu_regfile.sv
// Register file: REG_DEPTH x DATA_W, two combinational read ports, one
// synchronous write port. Addresses at or beyond REG_DEPTH read as zero and
// ignore writes.
module mini_alu_regfile #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int REG_DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] rd0_addr_i,
   output logic [DATA_W-1:0] rd0_data_o,
   input  logic [ADDR_W-1:0] rd1_addr_i,
   output logic [DATA_W-1:0] rd1_data_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [REG_DEPTH];

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return int'(addr) < REG_DEPTH;
   endfunction

   // Storage array with asynchronous clear and a single write port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the array must read zero right after reset, so it is built
         // from resettable flops; a RAM macro could not honour the clear.
         for (int i = 0; i < REG_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i && in_range(wr_addr_i)) begin
         mem_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
      end
   end

   assign rd0_data_o = in_range(rd0_addr_i) ? mem_q[rd0_addr_i[IDX_W-1:0]] : '0;
   assign rd1_data_o = in_range(rd1_addr_i) ? mem_q[rd1_addr_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/mini_alu_pipe.sv
// Two-stage ALU core: fetch into a decode register, execute against the
// register file. Taken branches flush one slot; OUT stalls until the
// consumer accepts the data; HALT freezes the core until reset.
module mini_alu_pipe
   import mini_alu_pipe_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int REG_DEPTH = 16,
   parameter int IP_W      = 16
) (
   input  logic                     Clock,
   input  logic                     Reset,
   output logic [IP_W-1:0]          oIP,
   input  logic [OP_W+3*ADDR_W-1:0] iInstruction,
   output logic [DATA_W-1:0]        oOutData,
   output logic                     oOutValid,
   input  logic                     iOutReady,
   output logic                     oHalted
);

   localparam int INSTR_W  = instr_w(ADDR_W);
   localparam int OP_LSB   = op_lsb(ADDR_W);
   localparam int DEST_LSB = dest_lsb(ADDR_W);
   localparam int SRC1_LSB = src1_lsb(ADDR_W);
   localparam int SRC0_LSB = src0_lsb(ADDR_W);
   localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {(3*ADDR_W){1'b0}}};

   state_e              state_q, state_d;
   logic [IP_W-1:0]     ip_q, ip_d;
   logic [INSTR_W-1:0]  dec_q, dec_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;

   opcode_e             op;
   logic [ADDR_W-1:0]   dest, src1, src0;
   logic [DATA_W-1:0]   rd0, rd1;
   logic                wr_en;
   logic [DATA_W-1:0]   wr_data;
   logic [2*DATA_W-1:0] op0_ext, op1_ext, prod;

   assign op   = opcode_e'(dec_q[OP_LSB +: OP_W]);
   assign dest = dec_q[DEST_LSB +: ADDR_W];
   assign src1 = dec_q[SRC1_LSB +: ADDR_W];
   assign src0 = dec_q[SRC0_LSB +: ADDR_W];

   // Sign-extend both operands so the truncated product is the signed one.
   assign op0_ext = {{DATA_W{rd0[DATA_W-1]}}, rd0};
   assign op1_ext = {{DATA_W{rd1[DATA_W-1]}}, rd1};
   assign prod    = op0_ext * op1_ext;

   mini_alu_regfile #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .REG_DEPTH (REG_DEPTH)
   ) u_regfile (
      .clk_i      (Clock),
      .rst_ni     (Reset),
      .rd0_addr_i (src0),
      .rd0_data_o (rd0),
      .rd1_addr_i (src1),
      .rd1_data_o (rd1),
      .wr_en_i    (wr_en),
      .wr_addr_i  (dest),
      .wr_data_i  (wr_data)
   );

   // Execute the decoded instruction and compute fetch / FSM next state
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch of
      // the case statements can leave one unassigned and infer a latch.
      state_d     = state_q;
      ip_d        = ip_q;
      dec_d       = dec_q;
      hi_d        = hi_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      wr_en       = 1'b0;
      wr_data     = '0;

      case (state_q)
         ST_RUN: begin
            ip_d  = ip_q + IP_W'(1);
            dec_d = iInstruction;
            case (op)
               OP_STO: begin
                  wr_en   = 1'b1;
                  wr_data = DATA_W'({src1, src0});
               end
               OP_ADD: begin
                  wr_en   = 1'b1;
                  wr_data = rd0 + rd1;
               end
               OP_SUB: begin
                  wr_en   = 1'b1;
                  wr_data = rd0 - rd1;
               end
               OP_SMUL: begin
                  wr_en   = 1'b1;
                  wr_data = prod[DATA_W-1:0];
                  hi_d    = prod[2*DATA_W-1:DATA_W];
               end
               OP_MFHI: begin
                  wr_en   = 1'b1;
                  wr_data = hi_q;
               end
               OP_BLE: begin
                  if (rd1 <= rd0) begin
                     ip_d  = IP_W'(dest);
                     dec_d = NOP_INSTR;
                  end
               end
               OP_JMP: begin
                  ip_d  = IP_W'(dest);
                  dec_d = NOP_INSTR;
               end
               OP_OUT: begin
                  out_data_d  = rd1;
                  out_valid_d = 1'b1;
                  state_d     = ST_WAIT_OUT;
               end
               OP_HALT: begin
                  ip_d    = ip_q;
                  dec_d   = dec_q;
                  state_d = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_WAIT_OUT: begin
            if (out_valid_q && iOutReady) begin
               out_valid_d = 1'b0;
               state_d     = ST_RUN;
            end
         end
         ST_HALT: ;
         default: state_d = ST_RUN;
      endcase
   end

   // Pipeline, HI, output port and FSM state registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_RUN;
         ip_q        <= '0;
         dec_q       <= NOP_INSTR;
         hi_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates let every register see the values from
         // before this edge, which is what makes the two stages independent.
         state_q     <= state_d;
         ip_q        <= ip_d;
         dec_q       <= dec_d;
         hi_q        <= hi_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign oIP       = ip_q;
   assign oOutData  = out_data_q;
   assign oOutValid = out_valid_q;
   assign oHalted   = (state_q == ST_HALT);

endmodule
